// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: owns the PC, drives the ROM, buffers {pc, inst} in a prefetch FIFO.
// Optional FETCH_MISALIGN_EXC_EN adds a sticky misaligned-branch-target exception (fetch_exc_o).
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        ce,
  output logic [31:0] addr,
  input  logic [31:0] inst_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  input  logic        id_ready_i
`ifdef FETCH_MISALIGN_EXC_EN
  ,
  output logic        fetch_exc_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   inst_mem [FIFO_DEPTH];

  logic          pop;
  logic          room;
  logic          fetch_go;
  logic          exc_blk;
  logic [31:0]   target;

`ifdef FETCH_MISALIGN_EXC_EN
  logic exc_q;

  // pc takes the raw target so addr exposes the faulting address
  assign target      = branch_target_address_i;
  assign exc_blk     = exc_q;
  assign fetch_exc_o = exc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_q <= 1'b0;
    end else if (branch_flag_i) begin
      exc_q <= |branch_target_address_i[1:0];
    end
  end
`else
  assign target  = branch_target_address_i & 32'hFFFF_FFFC;
  assign exc_blk = 1'b0;
`endif

  assign addr       = pc;
  assign if_valid_o = (count != '0);
  assign pop        = if_valid_o & id_ready_i;
  assign room       = (count < CW'(FIFO_DEPTH)) | pop;
  assign fetch_go   = ce & ~stall_i & room & ~branch_flag_i & ~exc_blk;

  assign if_pc_o   = if_valid_o ? pc_mem[head]   : 32'h0;
  assign if_inst_o = if_valid_o ? inst_mem[head] : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce    <= 1'b0;
      pc    <= RESET_PC;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      ce <= 1'b1;
      if (branch_flag_i) begin
        pc    <= target;
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (fetch_go) begin
          pc   <= pc + 32'd4;
          tail <= tail + PW'(1);
        end
        if (pop) begin
          head <= head + PW'(1);
        end
        case ({fetch_go, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Entry payload needs no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (fetch_go) begin
      pc_mem[tail]   <= pc;
      inst_mem[tail] <= inst_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based reference model checked every cycle, plus directed literal checks.
module tb_inst_fetch;

  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] target = 32'h0;
  logic        en = 1'b0;

  logic        ce, valid;
  logic [31:0] addr, inst, if_pc, if_inst;
  logic        ce_w, valid_w;
  logic [31:0] addr_w, inst_w, pc_w, inst_o_w;
`ifdef FETCH_MISALIGN_EXC_EN
  logic        exc, exc_w;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // ROM contents: word[n] = n
  assign inst   = addr >> 2;
  assign inst_w = addr_w >> 2;

  inst_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(branch),
    .branch_target_address_i(target), .ce(ce), .addr(addr), .inst_i(inst),
    .if_valid_o(valid), .if_pc_o(if_pc), .if_inst_o(if_inst), .id_ready_i(ready)
`ifdef FETCH_MISALIGN_EXC_EN
    , .fetch_exc_o(exc)
`endif
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_w (
    .clk(clk), .rst(rst), .stall_i(1'b0), .branch_flag_i(1'b0),
    .branch_target_address_i(32'h0), .ce(ce_w), .addr(addr_w), .inst_i(inst_w),
    .if_valid_o(valid_w), .if_pc_o(pc_w), .if_inst_o(inst_o_w), .id_ready_i(1'b1)
`ifdef FETCH_MISALIGN_EXC_EN
    , .fetch_exc_o(exc_w)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched {pc, inst} pairs
  logic [63:0] q[$];
  logic [31:0] m_pc  = RPC;
  logic        m_ce  = 1'b0;
  logic        m_exc = 1'b0;
  logic        m_pop, m_go;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ce  = 1'b0;
      m_pc  = RPC;
      m_exc = 1'b0;
      q.delete();
    end else begin
      m_pop = (q.size() != 0) && ready;
      if (branch) begin
        q.delete();
`ifdef FETCH_MISALIGN_EXC_EN
        m_pc  = target;
        m_exc = (target % 4) != 0;
`else
        m_pc  = target - (target % 4);
`endif
      end else begin
        m_go = m_ce && !stall && !m_exc && ((q.size() < DEPTH) || m_pop);
        if (m_pop) void'(q.pop_front());
        if (m_go) begin
          q.push_back({m_pc, m_pc / 4});
          m_pc = m_pc + 32'd4;
        end
      end
      m_ce = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("m_ce", {31'b0, ce}, {31'b0, m_ce});
      chk("m_addr", addr, m_pc);
      chk("m_valid", {31'b0, valid}, (q.size() != 0) ? 32'd1 : 32'd0);
      chk("m_if_pc", if_pc, (q.size() != 0) ? q[0][63:32] : 32'h0);
      chk("m_if_inst", if_inst, (q.size() != 0) ? q[0][31:0] : 32'h0);
`ifdef FETCH_MISALIGN_EXC_EN
      chk("m_exc", {31'b0, exc}, {31'b0, m_exc});
`endif
    end
  end

  logic [31:0] wexp [3];

  initial begin
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;

    #2 rst = 1'b0;
    en = 1'b1;
    @(negedge clk);
    chk("rst_ce", {31'b0, ce}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_w_addr", addr_w, 32'hFFFF_FFF8);
    @(negedge clk);
    #3 rst = 1'b1;

    // Reset release: ce first, then PCs 0,4,8 streaming
    @(negedge clk);
    chk("a_ce", {31'b0, ce}, 32'd1);
    chk("a_addr", addr, 32'h0);
    chk("a_valid", {31'b0, valid}, 32'd0);
    chk("a_w_ce", {31'b0, ce_w}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("a_pc", if_pc, 32'(i * 4));
      chk("a_inst", if_inst, 32'(i));
      chk("w_valid", {31'b0, valid_w}, 32'd1);
      chk("w_pc", pc_w, wexp[i]);
      chk("w_inst", inst_o_w, wexp[i] >> 2);
    end

    // Backpressure from a fresh reset
    #3 rst = 1'b0;
    @(negedge clk);
    ready = 1'b0;
    #3 rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("b_addr", addr, 32'h8);
    chk("b_pc", if_pc, 32'h0);
    chk("b_valid", {31'b0, valid}, 32'd1);
    ready = 1'b1;
    @(negedge clk);
    chk("b_pc4", if_pc, 32'h4);
    @(negedge clk);
    chk("b_pc8", if_pc, 32'h8);

    // Branch with full FIFO
    ready = 1'b0;
    repeat (3) @(negedge clk);
    branch = 1'b1;
    target = 32'h100;
    @(negedge clk);
    branch = 1'b0;
    chk("c_valid", {31'b0, valid}, 32'd0);
    chk("c_addr", addr, 32'h100);
    @(negedge clk);
    chk("c_pc", if_pc, 32'h100);
    chk("c_inst", if_inst, 32'h40);

    // Branch during stall
    stall  = 1'b1;
    branch = 1'b1;
    target = 32'h40;
    @(negedge clk);
    branch = 1'b0;
    chk("d_valid", {31'b0, valid}, 32'd0);
    chk("d_addr", addr, 32'h40);
    @(negedge clk);
    chk("d_valid2", {31'b0, valid}, 32'd0);
    chk("d_addr2", addr, 32'h40);
    stall = 1'b0;
    @(negedge clk);
    chk("d_pc", if_pc, 32'h40);
    chk("d_valid3", {31'b0, valid}, 32'd1);

    // Misaligned branch target
    branch = 1'b1;
    target = 32'h102;
    @(negedge clk);
    branch = 1'b0;
`ifdef FETCH_MISALIGN_EXC_EN
    chk("e_addr", addr, 32'h102);
    chk("e_exc", {31'b0, exc}, 32'd1);
    @(negedge clk);
    chk("e_valid", {31'b0, valid}, 32'd0);
    chk("e_exc2", {31'b0, exc}, 32'd1);
    branch = 1'b1;
    target = 32'h200;
    @(negedge clk);
    branch = 1'b0;
    chk("e_exc3", {31'b0, exc}, 32'd0);
    chk("e_addr2", addr, 32'h200);
    @(negedge clk);
    chk("e_pc", if_pc, 32'h200);
`else
    chk("e_addr", addr, 32'h100);
    @(negedge clk);
    chk("e_pc", if_pc, 32'h100);
`endif

    // Mixed stall/ready pattern with a branch in the middle
    for (int i = 0; i < 40; i++) begin
      stall  = (i % 7) == 3;
      ready  = (i % 3) != 0;
      branch = (i == 20);
      target = 32'h300;
      @(negedge clk);
    end
    branch = 1'b0;
    stall  = 1'b0;

    // Mid-operation asynchronous reset
    ready  = 1'b0;
    branch = 1'b1;
    target = 32'h18;
    @(negedge clk);
    branch = 1'b0;
    repeat (2) @(negedge clk);
    chk("f_addr", addr, 32'h20);
    chk("f_pc", if_pc, 32'h18);
    chk("f_valid", {31'b0, valid}, 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("f_rst_ce", {31'b0, ce}, 32'd0);
    chk("f_rst_addr", addr, RPC);
    chk("f_rst_valid", {31'b0, valid}, 32'd0);
    chk("f_rst_pc", if_pc, 32'h0);
    chk("f_rst_inst", if_inst, 32'h0);
    @(negedge clk);
    #3 rst = 1'b1;
    ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
